// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit_if
// Brief   : Request/response bundle between the core and the load/store unit.
// Rev     : 1.0
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, req_we, funct3, addr, wdata,
        input  busy, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata,
        output busy, rsp_valid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : RV32I load/store stage with a word-organised internal RAM and
//           programmable wait states; stalls the core while busy.
// Rev     : 1.0
// ============================================================================
module load_store_unit #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    load_store_unit_if.slave bus
);
    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [c_IDX_W+1:0]  r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [2:0]          r_funct3;
    logic                r_we;
    logic                r_err;
    logic [3:0]          r_cnt;
    logic [31:0]         r_mem [DEPTH];

    logic                w_legal;
    logic                w_accept;
    logic                w_commit;
    logic [c_IDX_W-1:0]  w_idx;
    logic [31:0]         w_word;
    logic [31:0]         w_load;
    logic [31:0]         w_wlane;
    logic [31:0]         w_merged;
    logic [3:0]          w_be;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_unused_addr;

    assign w_unused_addr = ^bus.addr[31:c_IDX_W+2];

    // A request is legal when funct3 names a supported access and the address is naturally aligned.
    always_comb begin
        w_legal = 1'b0;
        case (bus.funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~bus.addr[0];
            3'b010:  w_legal = (bus.addr[1:0] == 2'b00);
            3'b100:  w_legal = ~bus.req_we;
            3'b101:  w_legal = ~bus.req_we & ~bus.addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = w_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_commit   = 1'b1;
                    w_state_nx = RESP;
                end
            end
            RESP:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= bus.addr[c_IDX_W+1:0];
                r_wdata  <= bus.wdata;
                r_funct3 <= bus.funct3;
                r_we     <= bus.req_we;
                if (w_legal) begin
                    r_cnt <= c_WAIT;
                end else begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err   <= 1'b0;
                r_rdata <= r_we ? 32'd0 : w_load;
            end
        end
    end

    assign w_idx  = r_addr[c_IDX_W+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select what lands.
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_wlane = {4{r_wdata[7:0]}};
                w_be    = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_wlane = {2{r_wdata[15:0]}};
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wlane = r_wdata;
                w_be    = 4'b1111;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            w_merged[8*b +: 8] = w_be[b] ? w_wlane[8*b +: 8] : w_word[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && r_we && !rst) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign bus.busy      = ((r_state == IDLE) & bus.req_valid) | (r_state == ACCESS);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Self-checking bench: directed vector table, multi-cycle sequences
//           and randomized traffic against a byte-array reference model.
// Rev     : 1.0
// ============================================================================
module tb_load_store_unit;
    localparam int c_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rv  = '0;
    logic [2:0]  st  = '0;
    logic [2:0]  f3d [3];
    logic [31:0] ad  [3];
    logic [31:0] wdd [3];
    wire  [2:0]  bsy;
    wire  [2:0]  rsv;
    wire  [2:0]  er;
    wire  [2:0][31:0] rd;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mdl [3][64];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        load_store_unit_if u_if ();
        assign u_if.req_valid = rv[g];
        assign u_if.req_we    = st[g];
        assign u_if.funct3    = f3d[g];
        assign u_if.addr      = ad[g];
        assign u_if.wdata     = wdd[g];
        assign bsy[g]         = u_if.busy;
        assign rsv[g]         = u_if.rsp_valid;
        assign rd[g]          = u_if.rdata;
        assign er[g]          = u_if.err;
        load_store_unit #(
            .DEPTH       (c_DEPTH),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    function automatic int nbytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit model_legal(input bit is_st, input logic [2:0] f, input logic [31:0] a);
        bit ok_f3;
        ok_f3 = is_st ? (f <= 3'd2) : ((f <= 3'd2) || (f == 3'd4) || (f == 3'd5));
        return ok_f3 && ((a % nbytes(f)) == 0);
    endfunction

    function automatic int model_off(input logic [31:0] a);
        return int'(a % (4 * c_DEPTH)) - 'h100;
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [31:0] a, input logic [2:0] f);
        int     n;
        int     off;
        longint v;
        n   = nbytes(f);
        off = model_off(a);
        v   = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[k][off+i]) << (8 * i);
        if (!f[2] && (n < 4) && (v >= (64'sd1 << (8 * n - 1)))) v -= (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input int k, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        int off;
        off = model_off(a);
        for (int i = 0; i < nbytes(f); i++) mdl[k][off+i] = 8'(d >> (8 * i));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Presents one request on instance k starting at the current cycle (cycle 0)
    // and reports the cycle in which rsp_valid appeared.
    task automatic access(input int k, input bit is_st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input bit hold,
                          output logic [31:0] r, output logic e, output int lat);
        int busy_bad;
        busy_bad = 0;
        rv[k] = 1'b1; st[k] = is_st; f3d[k] = f; ad[k] = a; wdd[k] = d;
        lat = -1; r = '0; e = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (rsv[k]) begin
                lat = c; r = rd[k]; e = er[k];
                if (bsy[k]) busy_bad++;
                break;
            end
            if (!bsy[k]) busy_bad++;
            @(posedge clk); #1;
            if (!hold) rv[k] = 1'b0;
        end
        rv[k] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("busy_profile_k%0d", k), busy_bad, 0);
    endtask

    typedef struct {
        logic        is_st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [22];

    initial begin
        logic [31:0] r, d, a, exp_r;
        logic        e, exp_e, is_st, hold;
        logic [2:0]  f;
        int          lat;

        vecs = '{
            '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0},
            '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, 3'b000, 32'h13, 32'h00000080, 32'h00000000, 1'b0},
            '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0},
            '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0},
            '{1'b1, 3'b001, 32'h12, 32'h00001234, 32'h00000000, 1'b0},
            '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00001234, 1'b0},
            '{1'b0, 3'b001, 32'h11, 32'h0,        32'h00000000, 1'b1},
            '{1'b0, 3'b010, 32'h10, 32'h0,        32'h1234BEEF, 1'b0},
            '{1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h00000000, 1'b0},
            '{1'b1, 3'b010, 32'h16, 32'h11111111, 32'h00000000, 1'b1},
            '{1'b0, 3'b011, 32'h14, 32'h0,        32'h00000000, 1'b1},
            '{1'b1, 3'b011, 32'h14, 32'h22222222, 32'h00000000, 1'b1},
            '{1'b1, 3'b001, 32'h15, 32'h33333333, 32'h00000000, 1'b1},
            '{1'b1, 3'b100, 32'h14, 32'h44444444, 32'h00000000, 1'b1},
            '{1'b0, 3'b110, 32'h14, 32'h0,        32'h00000000, 1'b1},
            '{1'b0, 3'b010, 32'h12, 32'h0,        32'h00000000, 1'b1},
            '{1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFFCAFE, 1'b0},
            '{1'b0, 3'b101, 32'h14, 32'h0,        32'h0000F00D, 1'b0},
            '{1'b0, 3'b000, 32'h15, 32'h0,        32'hFFFFFFF0, 1'b0},
            '{1'b0, 3'b010, 32'h14, 32'h0,        32'hCAFEF00D, 1'b0}
        };
        for (int k = 0; k < 3; k++) begin
            f3d[k] = '0; ad[k] = '0; wdd[k] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy_k%0d", k), bsy[k], 0);
            chk($sformatf("reset_rsp_k%0d", k), rsv[k], 0);
            chk($sformatf("reset_rdata_k%0d", k), rd[k], 0);
            chk($sformatf("reset_err_k%0d", k), er[k], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors on the single-wait-state instance.
        for (int i = 0; i < 22; i++) begin
            access(0, vecs[i].is_st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1, r, e, lat);
            chk($sformatf("vec%0d_rdata", i), r, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), e, vecs[i].err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 1 : 3);
        end
        repeat (3) @(posedge clk);
        #3;
        chk("rdata_hold", rd[0], 32'hCAFEF00D);
        chk("err_hold", er[0], 0);

        // Zero wait states: back-to-back loads through an aliased address.
        access(1, 1'b1, 3'b010, 32'h10, 32'h01020304, 1'b1, r, e, lat);
        chk("ws0_store_latency", lat, 2);
        rv[1] = 1'b1; st[1] = 1'b0; f3d[1] = 3'b010; ad[1] = 32'h1010;
        for (int c = 0; c < 9; c++) begin
            #2;
            chk($sformatf("b2b_rsp_c%0d", c), rsv[1], (c % 3) == 2);
            if ((c % 3) == 2) chk($sformatf("b2b_rdata_c%0d", c), rd[1], 32'h01020304);
            @(posedge clk); #1;
        end
        rv[1] = 1'b0;
        @(posedge clk); #1;

        // Three wait states: reset lands in the second ACCESS cycle of a store.
        access(2, 1'b1, 3'b010, 32'h20, 32'hAAAAAAAA, 1'b1, r, e, lat);
        access(2, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, r, e, lat);
        chk("ws3_pre_rdata", r, 32'hAAAAAAAA);
        chk("ws3_latency", lat, 5);
        rv[2] = 1'b1; st[2] = 1'b1; f3d[2] = 3'b010; ad[2] = 32'h20; wdd[2] = 32'h55555555;
        @(posedge clk); #1;
        rv[2] = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_before", bsy[2], 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", bsy[2], 0);
        chk("abort_rsp", rsv[2], 0);
        chk("abort_rdata", rd[2], 0);
        chk("abort_err", er[2], 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(2, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, r, e, lat);
        chk("abort_ram_untouched", r, 32'hAAAAAAAA);
        chk("abort_followup_err", e, 0);

        // Randomized traffic over a preloaded 64-byte region, with random upper address bits.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                d = $urandom;
                a = 32'h100 + 32'(4 * w);
                access(k, 1'b1, 3'b010, a, d, 1'b1, r, e, lat);
                model_store(k, a, 3'b010, d);
            end
            for (int n = 0; n < 60; n++) begin
                is_st = 1'($urandom_range(0, 1));
                f     = 3'($urandom_range(0, 7));
                a     = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
                d     = $urandom;
                hold  = 1'($urandom_range(0, 1));
                exp_e = !model_legal(is_st, f, a);
                exp_r = '0;
                if (!exp_e) begin
                    if (is_st) model_store(k, a, f, d);
                    else       exp_r = model_load(k, a, f);
                end
                access(k, is_st, f, a, d, hold, r, e, lat);
                chk($sformatf("rnd_k%0d_n%0d_rdata", k, n), r, exp_r);
                chk($sformatf("rnd_k%0d_n%0d_err", k, n), e, exp_e);
                chk($sformatf("rnd_k%0d_n%0d_latency", k, n), lat, exp_e ? 1 : ws_of(k) + 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the core's ALU.
- Consumes the ALU result as the byte address and rs2 as store data, and executes RISC-V RV32I loads and stores against an internal word-organised data RAM with configurable wait states.
- Returns the sign- or zero-extended load data to the result mux.
- Drives a stall to the core while an access is in flight.

Parameters:
DEPTH, 1024, number of 32-bit words in the internal RAM (power of two, at least 4)
WAIT_STATES, 1, extra cycles per access (0..15)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  memory instruction present (the core's MemWrite or load decode)
req_we  input  1  1 = store, 0 = load
funct3  input  3  instr[14:12]; access size and sign
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2)
busy  output  1  stall request to the core; combinational
rsp_valid  output  1  one-cycle pulse when the access completes
rdata  output  32  extended load data; 0 for stores and errors
err  output  1  misaligned or illegal funct3; qualified by rsp_valid

Behaviour:
- Reset: state=IDLE, cnt=0, rsp_valid=0, rdata=0, err=0, all latched request registers 0. RAM contents are not reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE with req_valid=1:
  - On the edge, latch addr, funct3, req_we and wdata.
  - Legal request: cnt<=WAIT_STATES and go to ACCESS.
  - Illegal request: go directly to RESP with err<=1 and no RAM access.
- ACCESS:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the RAM operation on this edge, register rdata and err=0, and go to RESP.
  - ACCESS lasts WAIT_STATES+1 cycles.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. req_valid is ignored in RESP.
- busy = (state==IDLE & req_valid) | (state==ACCESS). busy is low in RESP, so the core retires the instruction at the end of that cycle.
- Latency, with the request presented in cycle 0:
  - Legal access: rsp_valid in cycle WAIT_STATES+2.
  - Error: rsp_valid in cycle 1.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal and sets err.
- Alignment:
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - A violation sets err.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes.
- Load data:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Store data:
  - Byte enables are derived from size and lane; only enabled bytes change.
  - SB writes wdata[7:0]; SH writes wdata[15:0]; SW writes the full word.
  - Stores return rdata=0.
- Each write is performed exactly once, regardless of how long the core holds req_valid.
- rdata and err hold their value after RESP until the next completion or reset.
- Reset asserted mid-operation:
  - Immediate return to IDLE and outputs cleared.
  - A store whose commit edge has not yet occurred is aborted; the RAM is untouched.
- req_valid deasserted during ACCESS is ignored; the latched request completes.

Test Plan:
- WAIT_STATES=1: SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> busy high in cycles 0-2, rsp_valid in cycle 3, rdata=0xDEADBEEF, err=0.
- SB 0x13 wdata=0x80, then LB 0x13 -> rdata=0xFFFFFF80. LBU 0x13 -> 0x00000080. LW 0x10 -> 0x80ADBEEF.
- SH 0x12 wdata=0x1234, then LHU 0x12 -> 0x00001234. LH 0x11 -> err=1, rsp_valid in cycle 1, rdata=0, no RAM change.
- Illegal requests SW addr=0x16 and load funct3=011 -> err=1. A following LW 0x14 shows the old data unchanged.
- WAIT_STATES=0: back-to-back LW -> rsp_valid every 3rd cycle. With DEPTH=1024, address 0x1010 aliases 0x10.
- WAIT_STATES=3: SW 0x20 with rst pulsed in the 2nd ACCESS cycle -> busy=0, rsp_valid=0 and rdata=0 immediately. A following LW 0x20 returns the pre-store value.
